// File: rtl/nvram_pkg.sv
// Shared types and default constants for the NVRAM upload responder.
package nvram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        QUIESCE,
        READY,
        FETCH
    } state_t;

    // Byte returned for any offset outside the uploaded image
    localparam logic [7:0] OOR_FILL = 8'hFF;

    localparam int          IOCTL_AW         = 25;
    localparam int          DEF_RAM_AW       = 10;
    localparam logic [9:0]  DEF_BASE_ADDR    = 10'h01D;
    localparam int          DEF_LENGTH       = 64;
    localparam int          DEF_RAM_LATENCY  = 2;
    localparam int          DEF_PAUSE_CYCLES = 16;

    // Counter width large enough for both the quiesce and the latency counts
    function automatic int timer_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/nvram_upload_ctrl_if.sv
// ioctl upload handshake plus the spare game-RAM read port.
// slave = the upload responder, master = hps_io/RAM side.
interface nvram_upload_ctrl_if
    import nvram_pkg::*;
#(
    parameter int RAM_AW = DEF_RAM_AW
);
    logic                ioctl_upload;
    logic                ioctl_rd;
    logic [IOCTL_AW-1:0] ioctl_addr;
    logic [7:0]          ioctl_din;
    logic                ioctl_wait;
    logic [RAM_AW-1:0]   ram_addr;
    logic                ram_rd;
    logic [7:0]          ram_dout;

    modport slave (
        input  ioctl_upload, ioctl_rd, ioctl_addr, ram_dout,
        output ioctl_din, ioctl_wait, ram_addr, ram_rd
    );

    modport master (
        output ioctl_upload, ioctl_rd, ioctl_addr, ram_dout,
        input  ioctl_din, ioctl_wait, ram_addr, ram_rd
    );
endinterface

// File: rtl/nvram_fetch_timer.sv
// Loadable down-counter with zero flag; shared by the quiesce delay and
// the RAM read latency count (the two are never active at the same time).
module nvram_fetch_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] count_reg;

    // Load has priority; decrement saturates at zero
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/nvram_upload_ctrl.sv
// HPS ioctl upload responder: pauses the game CPU, then answers each ioctl
// read with a byte from a window of game RAM. Offsets past the window
// return OOR_FILL.
// Optional: define NVRAM_UPLOAD_CHECKSUM_EN to append one extra byte at
// offset LENGTH holding the XOR of all bytes fetched in the session.
module nvram_upload_ctrl
    import nvram_pkg::*;
#(
    parameter int                RAM_AW       = DEF_RAM_AW,
    parameter logic [RAM_AW-1:0] BASE_ADDR    = RAM_AW'(DEF_BASE_ADDR),
    parameter int                LENGTH       = DEF_LENGTH,
    parameter int                RAM_LATENCY  = DEF_RAM_LATENCY,
    parameter int                PAUSE_CYCLES = DEF_PAUSE_CYCLES
) (
    input  logic               clk_25,
    input  logic               reset,
    nvram_upload_ctrl_if.slave bus,
    output logic               pause_cpu,
    output logic               busy
);
    localparam int                  TW    = timer_width(PAUSE_CYCLES, RAM_LATENCY);
    localparam logic [IOCTL_AW-1:0] LEN_A = IOCTL_AW'(LENGTH);

    state_t              state_reg;
    logic                upload_prev_reg;
    logic                pend_reg;
    logic [IOCTL_AW-1:0] pend_addr_reg;
    logic [7:0]          din_reg;
    logic                wait_reg;
    logic                pause_reg;
    logic                ram_rd_reg;
    logic [RAM_AW-1:0]   ram_addr_reg;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
    logic [7:0]          cks_reg;
`endif

    logic                start;
    logic                abort;
    logic                svc;
    logic                in_range;
    logic [IOCTL_AW-1:0] svc_addr;
    logic [7:0]          oor_data;
    logic                tmr_load;
    logic                tmr_dec;
    logic [TW-1:0]       tmr_val;
    logic                tmr_zero;

    // Request decode; a read latched during QUIESCE is served the moment the count ends
    always_comb begin
        start    = (state_reg == IDLE) && bus.ioctl_upload && !upload_prev_reg;
        abort    = (state_reg != IDLE) && !bus.ioctl_upload;
        svc_addr = pend_reg ? pend_addr_reg : bus.ioctl_addr;
        svc      = !abort &&
                   (((state_reg == READY) && bus.ioctl_rd) ||
                    ((state_reg == QUIESCE) && tmr_zero && (pend_reg || bus.ioctl_rd)));
        in_range = (svc_addr < LEN_A);
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
        oor_data = (svc_addr == LEN_A) ? cks_reg : OOR_FILL;
`else
        oor_data = OOR_FILL;
`endif
        tmr_load = start || (svc && in_range);
        tmr_val  = start ? TW'(PAUSE_CYCLES - 1) : TW'(RAM_LATENCY);
        tmr_dec  = (state_reg == QUIESCE) || (state_reg == FETCH);
    end

    nvram_fetch_timer #(.W(TW)) u_timer (
        .clk      (clk_25),
        .srst     (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Session FSM with registered outputs; dropping ioctl_upload wins over everything
    always_ff @(posedge clk_25) begin
        // Tracked through reset so an upload held high across reset does not restart
        upload_prev_reg <= bus.ioctl_upload;
        if (reset) begin
            state_reg     <= IDLE;
            pend_reg      <= 1'b0;
            pend_addr_reg <= '0;
            din_reg       <= 8'h00;
            wait_reg      <= 1'b0;
            pause_reg     <= 1'b0;
            ram_rd_reg    <= 1'b0;
            ram_addr_reg  <= '0;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
            cks_reg       <= 8'h00;
`endif
        end else begin
            ram_rd_reg <= 1'b0;
            if (abort) begin
                state_reg <= IDLE;
                wait_reg  <= 1'b0;
                pause_reg <= 1'b0;
                pend_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            pause_reg <= 1'b1;
                            wait_reg  <= 1'b1;
                            pend_reg  <= 1'b0;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
                            cks_reg   <= 8'h00;
`endif
                            state_reg <= QUIESCE;
                        end
                    end
                    QUIESCE: begin
                        if (bus.ioctl_rd && !pend_reg) begin
                            pend_reg      <= 1'b1;
                            pend_addr_reg <= bus.ioctl_addr;
                        end
                        if (tmr_zero) begin
                            wait_reg  <= 1'b0;
                            pend_reg  <= 1'b0;
                            state_reg <= READY;
                        end
                    end
                    READY: begin
                    end
                    FETCH: begin
                        if (tmr_zero) begin
                            din_reg   <= bus.ram_dout;
                            wait_reg  <= 1'b0;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
                            cks_reg   <= cks_reg ^ bus.ram_dout;
`endif
                            state_reg <= READY;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
                if (svc) begin
                    if (in_range) begin
                        wait_reg     <= 1'b1;
                        ram_addr_reg <= BASE_ADDR + svc_addr[RAM_AW-1:0];
                        ram_rd_reg   <= 1'b1;
                        state_reg    <= FETCH;
                    end else begin
                        din_reg      <= oor_data;
                        wait_reg     <= 1'b0;
                        state_reg    <= READY;
                    end
                end
            end
        end
    end

    assign bus.ioctl_din  = din_reg;
    assign bus.ioctl_wait = wait_reg;
    assign bus.ram_addr   = ram_addr_reg;
    assign bus.ram_rd     = ram_rd_reg;
    assign pause_cpu      = pause_reg;
    assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_nvram_upload_ctrl.sv
// Scoreboard bench for nvram_upload_ctrl: stimulus pushes expectations,
// a negedge monitor pops and compares as the DUT completes each transaction.
module tb_nvram_upload_ctrl;
    import nvram_pkg::*;

    localparam int         AW   = 10;
    localparam logic [9:0] BASE = 10'h01D;
    localparam int         LEN  = 64;

    logic clk_25 = 1'b0;
    logic reset  = 1'b1;
    logic pause_cpu;
    logic busy;

    always #5 clk_25 = ~clk_25;

    nvram_upload_ctrl_if #(.RAM_AW(AW)) ifc ();

    nvram_upload_ctrl dut (
        .clk_25    (clk_25),
        .reset     (reset),
        .bus       (ifc),
        .pause_cpu (pause_cpu),
        .busy      (busy)
    );

    // Game RAM model: two-cycle read latency from the ram_rd strobe
    logic [7:0]    mem [0:1023];
    logic [AW-1:0] ra_q;
    logic          rd_q = 1'b0;
    always @(posedge clk_25) begin
        rd_q <= ifc.ram_rd;
        if (ifc.ram_rd) ra_q <= ifc.ram_addr;
        if (rd_q) ifc.ram_dout <= mem[ra_q];
    end

    typedef enum {K_READ, K_START, K_ABORT} kind_t;
    typedef struct {
        kind_t         kind;
        string         name;
        logic [7:0]    din;
        int            waits;
        int            rds;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor
    exp_t          cur;
    bit            act_m  = 1'b0;
    bit            first  = 1'b0;
    int            wcnt;
    int            rcnt;
    logic [AW-1:0] raddr;
    logic          prev_up = 1'b0;

    always @(negedge clk_25) begin
        if (act_m) begin
            case (cur.kind)
                K_READ: begin
                    if (ifc.ram_rd) begin
                        rcnt++;
                        raddr = ifc.ram_addr;
                    end
                    if (ifc.ioctl_wait) begin
                        wcnt++;
                    end else begin
                        check({cur.name, " din"}, ifc.ioctl_din, cur.din);
                        if (cur.waits >= 0) check({cur.name, " waits"}, wcnt, cur.waits);
                        check({cur.name, " ram_rd"}, rcnt, cur.rds);
                        if (cur.rds > 0) check({cur.name, " ram_addr"}, raddr, cur.addr);
                        $display("txn %s: din=%02h waits=%0d ram_rd=%0d", cur.name, ifc.ioctl_din, wcnt, rcnt);
                        act_m = 1'b0;
                    end
                end
                K_START: begin
                    if (first) begin
                        check({cur.name, " pause_cpu"}, pause_cpu, 1);
                        check({cur.name, " busy"}, busy, 1);
                        first = 1'b0;
                    end
                    if (ifc.ioctl_wait) begin
                        wcnt++;
                    end else begin
                        check({cur.name, " waits"}, wcnt, cur.waits);
                        $display("txn %s: waits=%0d", cur.name, wcnt);
                        act_m = 1'b0;
                    end
                end
                default: begin
                    check({cur.name, " wait"}, ifc.ioctl_wait, 0);
                    check({cur.name, " pause_cpu"}, pause_cpu, 0);
                    check({cur.name, " busy"}, busy, 0);
                    check({cur.name, " din"}, ifc.ioctl_din, cur.din);
                    $display("txn %s: din=%02h", cur.name, ifc.ioctl_din);
                    act_m = 1'b0;
                end
            endcase
        end
        if (!act_m && sbq.size() > 0) begin
            if ((sbq[0].kind == K_READ  && ifc.ioctl_rd) ||
                (sbq[0].kind == K_START && ifc.ioctl_upload && !prev_up) ||
                (sbq[0].kind == K_ABORT && !ifc.ioctl_upload && prev_up)) begin
                cur   = sbq.pop_front();
                act_m = 1'b1;
                first = 1'b1;
                wcnt  = 0;
                rcnt  = 0;
                raddr = '0;
            end
        end
        prev_up = ifc.ioctl_upload;
    end

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || act_m) && n < 200) begin
            @(posedge clk_25);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL drain: %0d items pending, want 0", sbq.size());
            sbq.delete();
            act_m = 1'b0;
        end
        @(posedge clk_25);
    endtask

    logic [7:0] cks_model = 8'h00;
    logic [7:0] last_din  = 8'h00;

    task automatic issue_rd(input logic [24:0] off);
        @(posedge clk_25); #1;
        ifc.ioctl_rd   = 1'b1;
        ifc.ioctl_addr = off;
        @(posedge clk_25); #1;
        ifc.ioctl_rd   = 1'b0;
    endtask

    task automatic read_off(input logic [24:0] off, input string name, input bit quiesce);
        exp_t e;
        e.kind = K_READ;
        e.name = name;
        if (off < 25'(LEN)) begin
            e.addr  = BASE + off[9:0];
            e.din   = mem[e.addr];
            e.waits = quiesce ? -1 : 3;
            e.rds   = 1;
            cks_model = cks_model ^ e.din;
        end else begin
            e.addr  = '0;
            e.waits = 0;
            e.rds   = 0;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
            e.din   = (off == 25'(LEN)) ? cks_model : 8'hFF;
`else
            e.din   = 8'hFF;
`endif
        end
        sbq.push_back(e);
        issue_rd(off);
        drain();
        last_din = e.din;
    endtask

    task automatic start_session(input string name);
        exp_t e;
        e.kind  = K_START;
        e.name  = name;
        e.din   = 8'h00;
        e.waits = 16;
        e.rds   = 0;
        e.addr  = '0;
        sbq.push_back(e);
        cks_model = 8'h00;
        @(posedge clk_25); #1;
        ifc.ioctl_upload = 1'b1;
        drain();
    endtask

    task automatic end_session();
        @(posedge clk_25); #1;
        ifc.ioctl_upload = 1'b0;
        repeat (2) @(posedge clk_25);
    endtask

    task automatic check_reset(input string name);
        @(negedge clk_25);
        check({name, " din"}, ifc.ioctl_din, 8'h00);
        check({name, " wait"}, ifc.ioctl_wait, 0);
        check({name, " pause_cpu"}, pause_cpu, 0);
        check({name, " ram_addr"}, ifc.ram_addr, 0);
        check({name, " ram_rd"}, ifc.ram_rd, 0);
        check({name, " busy"}, busy, 0);
        $display("txn %s: outputs at reset values checked", name);
    endtask

    initial begin
        exp_t e;
        ifc.ioctl_upload = 1'b0;
        ifc.ioctl_rd     = 1'b0;
        ifc.ioctl_addr   = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < LEN; i++) mem[BASE + 10'(i)] = 8'(i) ^ 8'hA5;

        repeat (3) @(posedge clk_25);
        #1 reset = 1'b0;
        check_reset("reset");

        // Session 1: full window, then out-of-range offsets
        start_session("start1");
        for (int i = 0; i < LEN; i++) read_off(25'(i), $sformatf("rd%0d", i), 1'b0);
        read_off(25'd64, "rd64", 1'b0);
        read_off(25'd65, "rd65", 1'b0);
        read_off(25'h1000000, "rd_high", 1'b0);
        end_session();

        // Abort during FETCH: din keeps the previous byte
        start_session("start2");
        read_off(25'd7, "rd7", 1'b0);
        e.kind = K_ABORT;
        e.name = "abort";
        e.din  = last_din;
        e.waits = 0;
        e.rds  = 0;
        e.addr = '0;
        sbq.push_back(e);
        issue_rd(25'd10);
        @(posedge clk_25); #1;
        ifc.ioctl_upload = 1'b0;
        drain();

        // Read latched during QUIESCE
        cks_model = 8'h00;
        @(posedge clk_25); #1;
        ifc.ioctl_upload = 1'b1;
        repeat (3) @(posedge clk_25);
        read_off(25'd5, "rd_quiesce", 1'b1);

        // Reset mid-session with upload still high
        @(posedge clk_25); #1 reset = 1'b1;
        @(posedge clk_25); #1 reset = 1'b0;
        check_reset("reset_mid");
        end_session();

        // Checksum sessions
        for (int i = 0; i < LEN; i++) mem[BASE + 10'(i)] = 8'h3C;
        start_session("start3");
        for (int i = 0; i < LEN; i++) read_off(25'(i), $sformatf("c%0d", i), 1'b0);
        read_off(25'd64, "cks_3c", 1'b0);
        end_session();

        mem[BASE] = 8'h3D;
        start_session("start4");
        for (int i = 0; i < LEN; i++) read_off(25'(i), $sformatf("d%0d", i), 1'b0);
        read_off(25'd64, "cks_3d", 1'b0);
        end_session();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nvram_upload_ctrl.md
Name: nvram_upload_ctrl

Overview:
- Responder for the HPS ioctl *upload* direction, the reverse of the ROM download path that feeds dn_addr/dn_data/dn_wr.
- On each ioctl read request from hps_io, it fetches a byte from a window of game RAM (high-score / NVRAM area) through a spare RAM read port and returns it on ioctl_din.
- Sits in the emu top between hps_io and the game core. It pauses the core while the upload is active.

Parameters:
- RAM_AW, 10: game RAM address width.
- BASE_ADDR, 10'h01D: first RAM address of the uploaded window.
- LENGTH, 64: number of bytes in the window (1..2^RAM_AW - BASE_ADDR).
- RAM_LATENCY, 2: cycles from ram_rd to valid ram_dout (1..7).
- PAUSE_CYCLES, 16: quiesce delay after pause assertion before the first fetch.

Ports:
- clk_25 in 1: system clock, same clock as hps_io.
- reset in 1: synchronous, active-high.
- ioctl_upload in 1: upload session active.
- ioctl_rd in 1: one-cycle read strobe for ioctl_addr.
- ioctl_addr in 25: byte offset within the upload image.
- ioctl_din out 8: read data returned to hps_io.
- ioctl_wait out 1: high while the requested byte is not yet valid.
- pause_cpu out 1: halts the game CPU clock enable.
- ram_addr out RAM_AW: game RAM read address.
- ram_rd out 1: read strobe, one cycle.
- ram_dout in 8: game RAM read data.
- busy out 1: high whenever state is not IDLE.

Behaviour:
- Reset values: ioctl_din=8'h00, ioctl_wait=0, pause_cpu=0, ram_addr=0, ram_rd=0, busy=0, state=IDLE.
- IDLE:
  - On rising ioctl_upload: pause_cpu=1, ioctl_wait=1, load the pause counter with PAUSE_CYCLES-1, go to QUIESCE.
  - ioctl_rd in IDLE is ignored.
- QUIESCE:
  - Decrement the counter. At 0: ioctl_wait=0, go to READY.
  - If ioctl_rd arrives during QUIESCE, latch the address and service it immediately on entering READY. ioctl_wait stays 1 throughout.
- READY, on ioctl_rd (or a latched pending request):
  - ioctl_wait=1 on the next cycle.
  - If offset < LENGTH: ram_addr = BASE_ADDR + offset[RAM_AW-1:0], ram_rd pulses for 1 cycle, latency counter = RAM_LATENCY, go to FETCH.
  - If offset >= LENGTH (checksum slot excluded when the optional feature is enabled): ioctl_din=8'hFF, ioctl_wait stays 0, no RAM access, stay in READY.
- FETCH:
  - Count down. On the cycle ram_dout is valid: capture it into ioctl_din, ioctl_wait=0, go to READY.
  - Out-of-range result latency: 1 cycle. In-range result latency: RAM_LATENCY+1 cycles.
- Reads arriving while ioctl_wait=1 are a protocol violation and are dropped. The assertion bench checks that none occur.
- Falling ioctl_upload in any state:
  - Abort any fetch and discard its data.
  - ioctl_wait=0, pause_cpu=0, go to IDLE on the next cycle.
  - A ram_rd already issued is not retracted.
- reset mid-session: all outputs return to their reset values on the next edge, and the CPU is released.
- Offset arithmetic: ioctl_addr is compared at full 25 bits, so no wrap-around. Only the low RAM_AW bits are used for the RAM address.
- ioctl_din holds its last value between reads.

Optional Feature:
- Macro: NVRAM_UPLOAD_CHECKSUM_EN.
- Enabled:
  - Offset LENGTH returns the XOR of all bytes fetched in the current session.
  - The accumulator clears on session start and on reset.
  - The image length becomes LENGTH+1; offsets > LENGTH return 8'hFF.
- Disabled: no accumulator is built, and offset LENGTH returns 8'hFF.

Decomposition:
- Shared package nvram_pkg:
  - state enum with the values IDLE, QUIESCE, READY, FETCH;
  - OOR_FILL = 8'hFF;
  - the default-parameter constants.
- One natural sub-module, nvram_fetch_timer: a loadable down-counter with zero flag, reused for both the quiesce and latency counts.

Test Plan:
- Upload start, PAUSE_CYCLES=16: ioctl_upload 0->1 -> pause_cpu=1 next cycle, ioctl_wait=1 for 16 cycles, then 0.
- RAM[0x01D..0x05C]=offset^8'hA5, read offsets 0..63: each read gives ioctl_wait high for exactly 3 cycles (RAM_LATENCY=2); ioctl_din = offset^0xA5; ram_addr = 0x01D+offset.
- Read offset 64 and offset 25'h1000000 (feature off): ioctl_din=8'hFF, ioctl_wait never asserted, ram_rd never pulses.
- ioctl_rd during QUIESCE at offset 5: serviced right after the count ends; ioctl_din=RAM[0x022].
- Drop ioctl_upload during FETCH: ioctl_wait=0 and pause_cpu=0 next cycle; ioctl_din unchanged from its prior value.
- Checksum enabled, all 64 bytes = 8'h3C, then read offset 64: ioctl_din=8'h00. Same test with byte 0 = 8'h3D: ioctl_din=8'h01.
